// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider feeding nested horizontal and
// vertical counters, with sync, active-video, coordinate and line/frame strobe decodes.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          pix_tick,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > (2**CW) - 1 || V_TOTAL > (2**CW) - 1) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_bad_param
    $error("vga_timing_gen: zero-sized timing parameter");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic          h_last;
  logic          v_last;
  logic          hs_zone;
  logic          vs_zone;

  assign h_last = (h_count == H_LAST);
  assign v_last = (v_count == V_LAST);

  // Strobes are qualified by reset so an aborted line never emits a stray tick.
  assign pix_tick  = !reset && en && (div_cnt == DIV_LAST);
  assign line_end  = pix_tick && h_last;
  assign frame_end = line_end && v_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      h_count <= '0;
      v_count <= '0;
    end else if (en) begin
      if (div_cnt == DIV_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;
      if (pix_tick) begin
        if (h_last) begin
          h_count <= '0;
          if (v_last) v_count <= '0;
          else        v_count <= v_count + 1'b1;
        end else begin
          h_count <= h_count + 1'b1;
        end
      end
    end
  end

  assign hs_zone  = (h_count >= HS_START) && (h_count < HS_END);
  assign vs_zone  = (v_count >= VS_START) && (v_count < VS_END);
  assign hsync    = (hs_zone && !reset) ? SYNC_POL : !SYNC_POL;
  assign vsync    = (vs_zone && !reset) ? SYNC_POL : !SYNC_POL;
  assign video_on = !reset && (h_count < H_ACT) && (v_count < V_ACT);
  assign pixel_x  = video_on ? h_count : '0;
  assign pixel_y  = video_on ? v_count : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 mode plus a tiny 8x6 mode, checked every
// cycle against an arithmetic model driven by the count of enabled clocks since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    int cd, ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } cfg_t;

  localparam cfg_t CA = '{cd:4, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:1'b0};
  localparam cfg_t CB = '{cd:1, ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1, pol:1'b1};

  logic clk = 1'b0;
  logic reset;
  logic en;

  logic [11:0] h_count_a, v_count_a, pixel_x_a, pixel_y_a;
  logic        hsync_a, vsync_a, video_on_a, pix_tick_a, line_end_a, frame_end_a;
  logic [3:0]  h_count_b, v_count_b, pixel_x_b, pixel_y_b;
  logic        hsync_b, vsync_b, video_on_b, pix_tick_b, line_end_b, frame_end_b;

  int checks = 0;
  int errors = 0;
  longint n = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .en(en),
    .h_count(h_count_a), .v_count(v_count_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
    .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
    .pix_tick(pix_tick_a), .line_end(line_end_a), .frame_end(frame_end_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1), .CW(4)
  ) u_b (
    .clk(clk), .reset(reset), .en(en),
    .h_count(h_count_b), .v_count(v_count_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
    .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
    .pix_tick(pix_tick_b), .line_end(line_end_b), .frame_end(frame_end_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (%h) expected %0d", name, act, act, exp);
    end
  endtask

  // n = enabled clocks since the last reset edge; everything follows from it.
  always @(posedge clk) begin
    armed <= 1'b1;
    if (reset)   n <= 0;
    else if (en) n <= n + 1;
  end

  task automatic compare(input string tag, input cfg_t c,
                         input logic [31:0] h, input logic [31:0] v,
                         input logic [31:0] px, input logic [31:0] py,
                         input logic hs, input logic vs, input logic vo,
                         input logic pt, input logic le, input logic fe);
    longint ht, vt, pix, eh, ev;
    bit evo, ept, ele, efe, ehs, evs;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    pix = n / c.cd;
    eh  = pix % ht;
    ev  = (pix / ht) % vt;
    ept = !reset && en && ((n % c.cd) == c.cd - 1);
    ele = ept && (eh == ht - 1);
    efe = ele && (ev == vt - 1);
    evo = !reset && (eh < c.ha) && (ev < c.va);
    ehs = (!reset && eh >= c.ha + c.hf && eh < c.ha + c.hf + c.hs) ? c.pol : !c.pol;
    evs = (!reset && ev >= c.va + c.vf && ev < c.va + c.vf + c.vs) ? c.pol : !c.pol;
    chk({tag, "_h_count"},   h,  32'(eh));
    chk({tag, "_v_count"},   v,  32'(ev));
    chk({tag, "_pixel_x"},   px, evo ? 32'(eh) : 32'd0);
    chk({tag, "_pixel_y"},   py, evo ? 32'(ev) : 32'd0);
    chk({tag, "_hsync"},     32'(hs), 32'(ehs));
    chk({tag, "_vsync"},     32'(vs), 32'(evs));
    chk({tag, "_video_on"},  32'(vo), 32'(evo));
    chk({tag, "_pix_tick"},  32'(pt), 32'(ept));
    chk({tag, "_line_end"},  32'(le), 32'(ele));
    chk({tag, "_frame_end"}, 32'(fe), 32'(efe));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      compare("a", CA, h_count_a, v_count_a, pixel_x_a, pixel_y_a, hsync_a, vsync_a,
              video_on_a, pix_tick_a, line_end_a, frame_end_a);
      compare("b", CB, h_count_b, v_count_b, pixel_x_b, pixel_y_b, hsync_b, vsync_b,
              video_on_b, pix_tick_b, line_end_b, frame_end_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int le_k, fe1, fe2, per, vcnt, hcnt, fper;
  bit found, started, done, fstarted, fdone;

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    repeat (3) tick();
    chk("rst_hsync_a", 32'(hsync_a), 1);
    chk("rst_video_on_a", 32'(video_on_a), 0);
    chk("rst_h_count_a", h_count_a, 0);
    chk("rst_vsync_b", 32'(vsync_b), 0);
    chk("rst_pix_tick_b", 32'(pix_tick_b), 0);
    reset = 1'b0;
    #1;
    chk("release_video_on_a", 32'(video_on_a), 1);

    // Run one line of mode A with en dropped for 17 clocks at h_count=100.
    le_k = -1; fe1 = -1; fe2 = -1;
    for (int k = 1; k <= 5000 && le_k < 0; k++) begin
      tick();
      if (k == 3)   chk("first_pix_tick_a", 32'(pix_tick_a), 1);
      if (k == 4)   chk("h_after_tick_a", h_count_a, 1);
      if (k == 401) chk("frozen_h_count_a", h_count_a, 100);
      if (frame_end_b && fe1 < 0)      fe1 = k;
      else if (frame_end_b && fe2 < 0) fe2 = k;
      if (line_end_a) le_k = k;
      en = !(k >= 400 && k <= 416);
    end
    chk("late_line_end_a", 32'(le_k), 3216);
    chk("first_frame_end_b", 32'(fe1), 47);
    chk("second_frame_end_b", 32'(fe2), 95);

    // Abort mode A in the middle of its hsync pulse.
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      if (h_count_a == 12'd700) found = 1'b1;
      else tick();
    end
    chk("reached_h700_a", 32'(found), 1);
    chk("hsync_active_a", 32'(hsync_a), 0);
    reset = 1'b1;
    #1;
    chk("rst_hsync_forced_a", 32'(hsync_a), 1);
    chk("rst_vsync_forced_a", 32'(vsync_a), 1);
    chk("rst_video_off_a", 32'(video_on_a), 0);
    chk("rst_hsync_forced_b", 32'(hsync_b), 0);
    tick();
    chk("rst_clear_h_a", h_count_a, 0);
    chk("rst_clear_v_a", v_count_a, 0);
    chk("rst_clear_h_b", h_count_b, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_pix_tick_a", 32'(pix_tick_a), 1);
    tick();
    chk("post_rst_h_a", h_count_a, 1);

    // Reset together with en=0, then stay disabled.
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("idle_h_count_a", h_count_a, 0);
    chk("idle_v_count_b", v_count_b, 0);
    chk("idle_pix_tick_a", 32'(pix_tick_a), 0);
    chk("idle_line_end_b", 32'(line_end_b), 0);

    // Measure a full line of mode A and a full frame of mode B.
    en = 1'b1;
    started = 0; done = 0; fstarted = 0; fdone = 0;
    per = 0; vcnt = 0; hcnt = 0; fper = 0;
    for (int k = 0; k < 8000 && !done; k++) begin
      tick();
      if (started) begin
        per++;
        if (video_on_a) vcnt++;
        if (!hsync_a)   hcnt++;
        if (line_end_a) done = 1'b1;
      end else if (line_end_a) begin
        started = 1'b1;
      end
      if (fstarted && !fdone) begin
        fper++;
        if (frame_end_b) fdone = 1'b1;
      end else if (frame_end_b && !fstarted) begin
        fstarted = 1'b1;
      end
    end
    chk("line_period_a", 32'(per), 3200);
    chk("video_clks_a", 32'(vcnt), 2560);
    chk("hsync_clks_a", 32'(hcnt), 384);
    chk("frame_period_b", 32'(fper), 48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
